// File: rtl/axi_lite_arbiter.sv
// Shares one AXI4-Lite master port between N requesters. Read and write
// channels each run their own round-robin arbiter with one outstanding transaction.
module axi_lite_arbiter #(
    parameter int N = 2
) (
    input  logic            clk,
    input  logic            reset,
    // requester write address / data / response
    input  logic [N*32-1:0] s_axi_awaddr_i,
    input  logic [N*3-1:0]  s_axi_awprot_i,
    input  logic [N-1:0]    s_axi_awvalid_i,
    output logic [N-1:0]    s_axi_awready_o,
    input  logic [N*32-1:0] s_axi_wdata_i,
    input  logic [N*4-1:0]  s_axi_wstrb_i,
    input  logic [N-1:0]    s_axi_wvalid_i,
    output logic [N-1:0]    s_axi_wready_o,
    output logic [N*2-1:0]  s_axi_bresp_o,
    output logic [N-1:0]    s_axi_bvalid_o,
    input  logic [N-1:0]    s_axi_bready_i,
    // requester read address / data
    input  logic [N*32-1:0] s_axi_araddr_i,
    input  logic [N*3-1:0]  s_axi_arprot_i,
    input  logic [N-1:0]    s_axi_arvalid_i,
    output logic [N-1:0]    s_axi_arready_o,
    output logic [N*32-1:0] s_axi_rdata_o,
    output logic [N*2-1:0]  s_axi_rresp_o,
    output logic [N-1:0]    s_axi_rvalid_o,
    input  logic [N-1:0]    s_axi_rready_i,
    // shared master port
    output logic [31:0]     m_axi_awaddr_o,
    output logic [2:0]      m_axi_awprot_o,
    output logic            m_axi_awvalid_o,
    input  logic            m_axi_awready_i,
    output logic [31:0]     m_axi_wdata_o,
    output logic [3:0]      m_axi_wstrb_o,
    output logic            m_axi_wvalid_o,
    input  logic            m_axi_wready_i,
    input  logic [1:0]      m_axi_bresp_i,
    input  logic            m_axi_bvalid_i,
    output logic            m_axi_bready_o,
    output logic [31:0]     m_axi_araddr_o,
    output logic [2:0]      m_axi_arprot_o,
    output logic            m_axi_arvalid_o,
    input  logic            m_axi_arready_i,
    input  logic [31:0]     m_axi_rdata_i,
    input  logic [1:0]      m_axi_rresp_i,
    input  logic            m_axi_rvalid_i,
    output logic            m_axi_rready_o
);

    localparam int GW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } r_state_e;

    // Lowest requesting index at or above ptr; otherwise wrap to the lowest requesting index.
    function automatic logic [GW-1:0] rr_pick(input logic [N-1:0] req, input logic [GW-1:0] ptr);
        logic [GW-1:0] pick_any;
        logic [GW-1:0] pick_hi;
        logic          hit_hi;
        pick_any = {GW{1'b0}};
        pick_hi  = {GW{1'b0}};
        hit_hi   = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick_any = GW'(i);
                if (GW'(i) >= ptr) begin
                    pick_hi = GW'(i);
                    hit_hi  = 1'b1;
                end
            end
        end
        return hit_hi ? pick_hi : pick_any;
    endfunction

    function automatic logic [GW-1:0] wrap_inc(input logic [GW-1:0] g);
        return (g == GW'(N - 1)) ? {GW{1'b0}} : g + GW'(1);
    endfunction

    w_state_e      w_state_q;
    logic [GW-1:0] w_grant_q;
    logic [GW-1:0] w_ptr_q;
    logic          aw_done_q;
    logic          w_done_q;
    r_state_e      r_state_q;
    logic [GW-1:0] r_grant_q;
    logic [GW-1:0] r_ptr_q;

    logic [31:0] awaddr_a [N];
    logic [2:0]  awprot_a [N];
    logic [31:0] wdata_a  [N];
    logic [3:0]  wstrb_a  [N];
    logic [31:0] araddr_a [N];
    logic [2:0]  arprot_a [N];

    logic w_addr_ph_s;
    logic w_resp_ph_s;
    logic r_addr_ph_s;
    logic r_data_ph_s;
    logic aw_hs_s;
    logic w_hs_s;
    logic b_hs_s;
    logic ar_hs_s;
    logic r_hs_s;

    // Split the flat requester buses into per-requester slices
    always_comb begin
        for (int i = 0; i < N; i++) begin
            awaddr_a[i] = s_axi_awaddr_i[i*32 +: 32];
            awprot_a[i] = s_axi_awprot_i[i*3 +: 3];
            wdata_a[i]  = s_axi_wdata_i[i*32 +: 32];
            wstrb_a[i]  = s_axi_wstrb_i[i*4 +: 4];
            araddr_a[i] = s_axi_araddr_i[i*32 +: 32];
            arprot_a[i] = s_axi_arprot_i[i*3 +: 3];
        end
    end

    assign w_addr_ph_s = (w_state_q == W_ADDR);
    assign w_resp_ph_s = (w_state_q == W_RESP);
    assign r_addr_ph_s = (r_state_q == R_ADDR);
    assign r_data_ph_s = (r_state_q == R_DATA);

    // Master request side is steered from the granted slice; done flags stop a second AW/W beat.
    assign m_axi_awvalid_o = w_addr_ph_s & s_axi_awvalid_i[w_grant_q] & ~aw_done_q;
    assign m_axi_awaddr_o  = w_addr_ph_s ? awaddr_a[w_grant_q] : 32'h0000_0000;
    assign m_axi_awprot_o  = w_addr_ph_s ? awprot_a[w_grant_q] : 3'b000;
    assign m_axi_wvalid_o  = w_addr_ph_s & s_axi_wvalid_i[w_grant_q] & ~w_done_q;
    assign m_axi_wdata_o   = w_addr_ph_s ? wdata_a[w_grant_q] : 32'h0000_0000;
    assign m_axi_wstrb_o   = w_addr_ph_s ? wstrb_a[w_grant_q] : 4'h0;
    assign m_axi_bready_o  = w_resp_ph_s & s_axi_bready_i[w_grant_q];

    assign m_axi_arvalid_o = r_addr_ph_s & s_axi_arvalid_i[r_grant_q];
    assign m_axi_araddr_o  = r_addr_ph_s ? araddr_a[r_grant_q] : 32'h0000_0000;
    assign m_axi_arprot_o  = r_addr_ph_s ? arprot_a[r_grant_q] : 3'b000;
    assign m_axi_rready_o  = r_data_ph_s & s_axi_rready_i[r_grant_q];

    assign aw_hs_s = m_axi_awvalid_o & m_axi_awready_i;
    assign w_hs_s  = m_axi_wvalid_o & m_axi_wready_i;
    assign b_hs_s  = m_axi_bvalid_i & m_axi_bready_o;
    assign ar_hs_s = m_axi_arvalid_o & m_axi_arready_i;
    assign r_hs_s  = m_axi_rvalid_i & m_axi_rready_o;

    // Per-requester readies and responses; everything outside the grant stays at zero
    always_comb begin
        for (int i = 0; i < N; i++) begin
            s_axi_awready_o[i]       = w_addr_ph_s & (w_grant_q == GW'(i)) & m_axi_awready_i & ~aw_done_q;
            s_axi_wready_o[i]        = w_addr_ph_s & (w_grant_q == GW'(i)) & m_axi_wready_i & ~w_done_q;
            s_axi_bvalid_o[i]        = w_resp_ph_s & (w_grant_q == GW'(i)) & m_axi_bvalid_i;
            s_axi_bresp_o[i*2 +: 2]  = (w_resp_ph_s && (w_grant_q == GW'(i))) ? m_axi_bresp_i : 2'b00;
            s_axi_arready_o[i]       = r_addr_ph_s & (r_grant_q == GW'(i)) & m_axi_arready_i;
            s_axi_rvalid_o[i]        = r_data_ph_s & (r_grant_q == GW'(i)) & m_axi_rvalid_i;
            s_axi_rdata_o[i*32 +: 32] = (r_data_ph_s && (r_grant_q == GW'(i))) ? m_axi_rdata_i : 32'h0000_0000;
            s_axi_rresp_o[i*2 +: 2]  = (r_data_ph_s && (r_grant_q == GW'(i))) ? m_axi_rresp_i : 2'b00;
        end
    end

    // Write channel: arbitrate on awvalid, track AW/W completion in any order, wait for B
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            w_grant_q <= {GW{1'b0}};
            w_ptr_q   <= {GW{1'b0}};
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                    if (|s_axi_awvalid_i) begin
                        w_grant_q <= rr_pick(s_axi_awvalid_i, w_ptr_q);
                        w_state_q <= W_ADDR;
                    end
                end
                W_ADDR: begin
                    if (aw_hs_s) begin
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs_s) begin
                        w_done_q <= 1'b1;
                    end
                    if ((aw_done_q | aw_hs_s) & (w_done_q | w_hs_s)) begin
                        w_state_q <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (b_hs_s) begin
                        w_ptr_q   <= wrap_inc(w_grant_q);
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // Read channel: arbitrate on arvalid, forward AR, then hold grant until the R beat completes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            r_grant_q <= {GW{1'b0}};
            r_ptr_q   <= {GW{1'b0}};
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (|s_axi_arvalid_i) begin
                        r_grant_q <= rr_pick(s_axi_arvalid_i, r_ptr_q);
                        r_state_q <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (ar_hs_s) begin
                        r_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_hs_s) begin
                        r_ptr_q   <= wrap_inc(r_grant_q);
                        r_state_q <= R_IDLE;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter with N=2: hand-computed expectations checked
// with immediate assertions at each step.
module tb_axi_lite_arbiter;

    localparam int N = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N*32-1:0] s_axi_awaddr;
    logic [N*3-1:0]  s_axi_awprot;
    logic [N-1:0]    s_axi_awvalid;
    logic [N-1:0]    s_axi_awready;
    logic [N*32-1:0] s_axi_wdata;
    logic [N*4-1:0]  s_axi_wstrb;
    logic [N-1:0]    s_axi_wvalid;
    logic [N-1:0]    s_axi_wready;
    logic [N*2-1:0]  s_axi_bresp;
    logic [N-1:0]    s_axi_bvalid;
    logic [N-1:0]    s_axi_bready;
    logic [N*32-1:0] s_axi_araddr;
    logic [N*3-1:0]  s_axi_arprot;
    logic [N-1:0]    s_axi_arvalid;
    logic [N-1:0]    s_axi_arready;
    logic [N*32-1:0] s_axi_rdata;
    logic [N*2-1:0]  s_axi_rresp;
    logic [N-1:0]    s_axi_rvalid;
    logic [N-1:0]    s_axi_rready;
    logic [31:0]     m_axi_awaddr;
    logic [2:0]      m_axi_awprot;
    logic            m_axi_awvalid;
    logic            m_axi_awready;
    logic [31:0]     m_axi_wdata;
    logic [3:0]      m_axi_wstrb;
    logic            m_axi_wvalid;
    logic            m_axi_wready;
    logic [1:0]      m_axi_bresp;
    logic            m_axi_bvalid;
    logic            m_axi_bready;
    logic [31:0]     m_axi_araddr;
    logic [2:0]      m_axi_arprot;
    logic            m_axi_arvalid;
    logic            m_axi_arready;
    logic [31:0]     m_axi_rdata;
    logic [1:0]      m_axi_rresp;
    logic            m_axi_rvalid;
    logic            m_axi_rready;

    int n_cmp = 0;
    int n_err = 0;

    axi_lite_arbiter #(.N(N)) dut (
        .clk             (clk),
        .reset           (reset),
        .s_axi_awaddr_i  (s_axi_awaddr),
        .s_axi_awprot_i  (s_axi_awprot),
        .s_axi_awvalid_i (s_axi_awvalid),
        .s_axi_awready_o (s_axi_awready),
        .s_axi_wdata_i   (s_axi_wdata),
        .s_axi_wstrb_i   (s_axi_wstrb),
        .s_axi_wvalid_i  (s_axi_wvalid),
        .s_axi_wready_o  (s_axi_wready),
        .s_axi_bresp_o   (s_axi_bresp),
        .s_axi_bvalid_o  (s_axi_bvalid),
        .s_axi_bready_i  (s_axi_bready),
        .s_axi_araddr_i  (s_axi_araddr),
        .s_axi_arprot_i  (s_axi_arprot),
        .s_axi_arvalid_i (s_axi_arvalid),
        .s_axi_arready_o (s_axi_arready),
        .s_axi_rdata_o   (s_axi_rdata),
        .s_axi_rresp_o   (s_axi_rresp),
        .s_axi_rvalid_o  (s_axi_rvalid),
        .s_axi_rready_i  (s_axi_rready),
        .m_axi_awaddr_o  (m_axi_awaddr),
        .m_axi_awprot_o  (m_axi_awprot),
        .m_axi_awvalid_o (m_axi_awvalid),
        .m_axi_awready_i (m_axi_awready),
        .m_axi_wdata_o   (m_axi_wdata),
        .m_axi_wstrb_o   (m_axi_wstrb),
        .m_axi_wvalid_o  (m_axi_wvalid),
        .m_axi_wready_i  (m_axi_wready),
        .m_axi_bresp_i   (m_axi_bresp),
        .m_axi_bvalid_i  (m_axi_bvalid),
        .m_axi_bready_o  (m_axi_bready),
        .m_axi_araddr_o  (m_axi_araddr),
        .m_axi_arprot_o  (m_axi_arprot),
        .m_axi_arvalid_o (m_axi_arvalid),
        .m_axi_arready_i (m_axi_arready),
        .m_axi_rdata_i   (m_axi_rdata),
        .m_axi_rresp_i   (m_axi_rresp),
        .m_axi_rvalid_i  (m_axi_rvalid),
        .m_axi_rready_o  (m_axi_rready)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 2'b11;
        s_axi_wdata = '0;  s_axi_wstrb = '0;  s_axi_wvalid = 2'b11;
        s_axi_bready = '0; s_axi_araddr = '0; s_axi_arprot = '0;
        s_axi_arvalid = 2'b11; s_axi_rready = '0;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bresp = 2'b00; m_axi_bvalid = 1'b1;
        m_axi_arready = 1'b1; m_axi_rdata = 32'hFFFF_FFFF; m_axi_rresp = 2'b00; m_axi_rvalid = 1'b1;
        #2;
        // reset holds everything quiet even with requests and master responses present
        chk("rst_m_awvalid", {63'd0, m_axi_awvalid}, 64'd0);
        chk("rst_m_wvalid",  {63'd0, m_axi_wvalid},  64'd0);
        chk("rst_m_arvalid", {63'd0, m_axi_arvalid}, 64'd0);
        chk("rst_m_bready",  {63'd0, m_axi_bready},  64'd0);
        chk("rst_m_rready",  {63'd0, m_axi_rready},  64'd0);
        chk("rst_s_readies", {58'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 64'd0);
        chk("rst_s_valids",  {60'd0, s_axi_bvalid, s_axi_rvalid}, 64'd0);
        chk("rst_s_rdata",   s_axi_rdata, 64'd0);
        tick();
        reset = 1'b0;
        s_axi_awvalid = 2'b00; s_axi_wvalid = 2'b00; s_axi_arvalid = 2'b00;
        m_axi_bvalid = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = 32'h0;

        // single read from requester 1
        tick();
        s_axi_araddr = {32'h2000_0010, 32'h0000_0000};
        s_axi_arvalid = 2'b10;
        m_axi_arready = 1'b1;
        #1;
        chk("t1_bubble_arvalid", {63'd0, m_axi_arvalid}, 64'd0);
        tick(); #1;
        chk("t1_arvalid", {63'd0, m_axi_arvalid}, 64'd1);
        chk("t1_araddr",  {32'd0, m_axi_araddr}, 64'h2000_0010);
        chk("t1_arready", {62'd0, s_axi_arready}, 64'b10);
        tick();
        s_axi_arvalid = 2'b00;
        m_axi_rvalid = 1'b1; m_axi_rdata = 32'hDEAD_BEEF; s_axi_rready = 2'b10;
        #1;
        chk("t1_rdata",   s_axi_rdata, 64'hDEAD_BEEF_0000_0000);
        chk("t1_rvalid",  {62'd0, s_axi_rvalid}, 64'b10);
        chk("t1_rready",  {63'd0, m_axi_rready}, 64'd1);
        chk("t1_ar_done", {63'd0, m_axi_arvalid}, 64'd0);
        tick();
        #1;
        chk("t1_idle_rvalid", {62'd0, s_axi_rvalid}, 64'b00);
        m_axi_rvalid = 1'b0; s_axi_rready = 2'b00;

        // contention: 0 first, then 1 while 0 re-requests, then 0 again
        tick();
        s_axi_araddr = {32'h0000_0200, 32'h0000_0100};
        s_axi_arvalid = 2'b11;
        #1;
        chk("t2_bubble", {63'd0, m_axi_arvalid}, 64'd0);
        tick(); #1;
        chk("t2_g0_addr",    {32'd0, m_axi_araddr}, 64'h100);
        chk("t2_g0_arready", {62'd0, s_axi_arready}, 64'b01);
        tick();
        s_axi_araddr = {32'h0000_0200, 32'h0000_0104};
        m_axi_rvalid = 1'b1; m_axi_rdata = 32'h1111_1111; s_axi_rready = 2'b11;
        #1;
        chk("t2_g0_rvalid", {62'd0, s_axi_rvalid}, 64'b01);
        chk("t2_g0_rdata",  s_axi_rdata, 64'h0000_0000_1111_1111);
        tick();
        m_axi_rvalid = 1'b0;
        #1;
        chk("t2_bubble2", {63'd0, m_axi_arvalid}, 64'd0);
        tick(); #1;
        chk("t2_g1_addr",    {32'd0, m_axi_araddr}, 64'h200);
        chk("t2_g1_arready", {62'd0, s_axi_arready}, 64'b10);
        tick();
        s_axi_arvalid = 2'b01;
        m_axi_rvalid = 1'b1; m_axi_rdata = 32'h2222_2222;
        #1;
        chk("t2_g1_rvalid", {62'd0, s_axi_rvalid}, 64'b10);
        chk("t2_g1_rdata",  s_axi_rdata, 64'h2222_2222_0000_0000);
        tick();
        m_axi_rvalid = 1'b0;
        tick(); #1;
        chk("t2_g0b_addr", {32'd0, m_axi_araddr}, 64'h104);
        tick();
        s_axi_arvalid = 2'b00;
        m_axi_rvalid = 1'b1; m_axi_rdata = 32'h3333_3333;
        tick();
        m_axi_rvalid = 1'b0; s_axi_rready = 2'b00;

        // read backpressure from requester 1
        tick();
        s_axi_araddr = {32'h0000_0300, 32'h0000_0000};
        s_axi_arvalid = 2'b10;
        tick();
        tick();
        s_axi_arvalid = 2'b00;
        m_axi_rvalid = 1'b1; m_axi_rdata = 32'hCAFE_F00D; s_axi_rready = 2'b00;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("t3_stall_rready", {63'd0, m_axi_rready}, 64'd0);
            chk("t3_stall_rdata",  s_axi_rdata, 64'hCAFE_F00D_0000_0000);
            chk("t3_stall_rvalid", {62'd0, s_axi_rvalid}, 64'b10);
            tick();
        end
        s_axi_rready = 2'b10;
        #1;
        chk("t3_release_rready", {63'd0, m_axi_rready}, 64'd1);
        tick(); #1;
        chk("t3_done_rvalid", {62'd0, s_axi_rvalid}, 64'b00);
        m_axi_rvalid = 1'b0; s_axi_rready = 2'b00;

        // write from requester 0: W offered before AW, then W completes before AW
        tick();
        s_axi_wdata = {32'h0, 32'hA5A5_A5A5}; s_axi_wstrb = 8'h0F; s_axi_wvalid = 2'b01;
        m_axi_wready = 1'b1; m_axi_awready = 1'b0;
        #1;
        chk("t4_early_wvalid", {63'd0, m_axi_wvalid}, 64'd0);
        chk("t4_early_wready", {62'd0, s_axi_wready}, 64'b00);
        tick();
        tick();
        tick();
        s_axi_awaddr = {32'h0, 32'h0000_1000}; s_axi_awprot = 6'b000_010; s_axi_awvalid = 2'b01;
        #1;
        chk("t4_bubble_awvalid", {63'd0, m_axi_awvalid}, 64'd0);
        tick(); #1;
        chk("t4_awvalid", {63'd0, m_axi_awvalid}, 64'd1);
        chk("t4_wvalid",  {63'd0, m_axi_wvalid},  64'd1);
        chk("t4_awaddr",  {32'd0, m_axi_awaddr}, 64'h1000);
        chk("t4_awprot",  {61'd0, m_axi_awprot}, 64'd2);
        chk("t4_wdata",   {32'd0, m_axi_wdata},  64'hA5A5_A5A5);
        chk("t4_wstrb",   {60'd0, m_axi_wstrb},  64'hF);
        chk("t4_awready_held", {62'd0, s_axi_awready}, 64'b00);
        chk("t4_wready",  {62'd0, s_axi_wready}, 64'b01);
        tick();
        m_axi_awready = 1'b1;
        #1;
        chk("t4_w_gated",    {63'd0, m_axi_wvalid}, 64'd0);
        chk("t4_wready_off", {62'd0, s_axi_wready}, 64'b00);
        chk("t4_awready",    {62'd0, s_axi_awready}, 64'b01);
        tick();
        s_axi_awvalid = 2'b00; s_axi_wvalid = 2'b00;
        m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00; s_axi_bready = 2'b01;
        #1;
        chk("t4_single_aw", {63'd0, m_axi_awvalid}, 64'd0);
        chk("t4_bvalid",    {62'd0, s_axi_bvalid}, 64'b01);
        chk("t4_bresp",     {60'd0, s_axi_bresp},  64'd0);
        chk("t4_bready",    {63'd0, m_axi_bready}, 64'd1);
        tick();
        m_axi_bvalid = 1'b0; s_axi_bready = 2'b00;

        // write from 0 and read from 1 together; stalled R does not block B
        tick();
        s_axi_awaddr = {32'h0, 32'h0000_2000}; s_axi_awvalid = 2'b01;
        s_axi_wdata = {32'h0, 32'h1234_5678}; s_axi_wvalid = 2'b01;
        s_axi_araddr = {32'h0000_3000, 32'h0}; s_axi_arvalid = 2'b10;
        #1;
        chk("t5_bubble", {62'd0, m_axi_awvalid, m_axi_arvalid}, 64'b00);
        tick(); #1;
        chk("t5_both_valid", {62'd0, m_axi_awvalid, m_axi_arvalid}, 64'b11);
        chk("t5_araddr",     {32'd0, m_axi_araddr}, 64'h3000);
        tick();
        s_axi_awvalid = 2'b00; s_axi_wvalid = 2'b00; s_axi_arvalid = 2'b00;
        m_axi_rvalid = 1'b0; s_axi_rready = 2'b10;
        m_axi_bvalid = 1'b1; m_axi_bresp = 2'b10; s_axi_bready = 2'b01;
        #1;
        chk("t5_bvalid",       {62'd0, s_axi_bvalid}, 64'b01);
        chk("t5_bresp",        {60'd0, s_axi_bresp},  64'b0010);
        chk("t5_rvalid_stall", {62'd0, s_axi_rvalid}, 64'b00);
        tick(); #1;
        chk("t5_b_complete", {62'd0, s_axi_bvalid}, 64'b00);
        m_axi_bvalid = 1'b0; s_axi_bready = 2'b00;
        m_axi_rvalid = 1'b1; m_axi_rdata = 32'h0BAD_F00D;
        #1;
        chk("t5_rvalid", {62'd0, s_axi_rvalid}, 64'b10);
        chk("t5_rdata",  s_axi_rdata, 64'h0BAD_F00D_0000_0000);
        tick();
        m_axi_rvalid = 1'b0; s_axi_rready = 2'b00;

        // reset while requester 1 sits in the write address phase
        tick();
        s_axi_awaddr = {32'h0000_4000, 32'h0}; s_axi_awvalid = 2'b10;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        tick(); #1;
        chk("t6_pre_awvalid", {63'd0, m_axi_awvalid}, 64'd1);
        chk("t6_pre_awaddr",  {32'd0, m_axi_awaddr}, 64'h4000);
        reset = 1'b1;
        #1;
        chk("t6_rst_awvalid", {63'd0, m_axi_awvalid}, 64'd0);
        chk("t6_rst_awaddr",  {32'd0, m_axi_awaddr}, 64'd0);
        tick();
        reset = 1'b0;
        s_axi_awaddr = {32'h0000_4000, 32'h0000_5000}; s_axi_awvalid = 2'b11;
        #1;
        chk("t6_idle_awvalid", {63'd0, m_axi_awvalid}, 64'd0);
        tick(); #1;
        chk("t6_regrant_awvalid", {63'd0, m_axi_awvalid}, 64'd1);
        chk("t6_regrant_awaddr",  {32'd0, m_axi_awaddr}, 64'h5000);
        m_axi_awready = 1'b1;
        #1;
        chk("t6_regrant_awready", {62'd0, s_axi_awready}, 64'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
